// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a CPU valid/ready port
// and a line-burst memory port (write-back beats out, fill beats in).
module dcache_wb #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned SETS       = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req_valid,
  input  logic                cpu_req_we,
  input  logic [ADDR_W-1:0]   cpu_req_addr,
  input  logic [DATA_W-1:0]   cpu_req_wdata,
  input  logic [DATA_W/8-1:0] cpu_req_wstrb,
  output logic                cpu_req_ready,
  output logic                cpu_resp_valid,
  output logic [DATA_W-1:0]   cpu_resp_rdata,
  output logic                mem_req_valid,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  output logic                mem_wvalid,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_wready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned BOFF_W = $clog2(STRB_W);
  localparam int unsigned WOFF_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = WOFF_W + BOFF_W;
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [2:0] {
    StIdle, StTag, StEvictReq, StEvictData, StFillReq, StFillData, StReplay
  } state_e;

  state_e state_q, state_d;

  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [STRB_W-1:0] req_wstrb_q;
  logic [WOFF_W-1:0] beat_q;

  logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  logic [IDX_W-1:0]  idx;
  logic [WOFF_W-1:0] word;
  logic [TAG_W-1:0]  req_tag;
  logic              accept, hit, do_access, wr_store, wbeat, rbeat, last_beat;
  logic              unused_addr;

  assign idx         = req_addr_q[OFF_W +: IDX_W];
  assign word        = req_addr_q[BOFF_W +: WOFF_W];
  assign req_tag     = req_addr_q[ADDR_W-1 -: TAG_W];
  assign unused_addr = ^req_addr_q[BOFF_W-1:0];

  assign accept    = cpu_req_valid && cpu_req_ready;
  assign hit       = valid_q[idx] && (tag_q[idx] == req_tag);
  // REPLAY repeats the TAG hit action on the freshly filled line
  assign do_access = ((state_q == StTag) && hit) || (state_q == StReplay);
  assign wr_store  = do_access && req_we_q;
  assign wbeat     = (state_q == StEvictData) && mem_wready;
  assign rbeat     = (state_q == StFillData) && mem_rvalid;
  assign last_beat = (beat_q == WOFF_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      beat_q      <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_we_q    <= cpu_req_we;
        req_addr_q  <= cpu_req_addr;
        req_wdata_q <= cpu_req_wdata;
        req_wstrb_q <= cpu_req_wstrb;
      end
      // Counter wraps to 0 naturally after the last beat of each burst
      if (wbeat || rbeat) beat_q <= beat_q + 1'b1;
      if (rbeat && last_beat) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (wr_store) dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rbeat) data_q[idx][beat_q] <= mem_rdata;
    if (rbeat && last_beat) tag_q[idx] <= req_tag;
    if (wr_store) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (req_wstrb_q[b]) data_q[idx][word][8*b +: 8] <= req_wdata_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (accept) state_d = StTag;
      StTag: begin
        if (hit)                              state_d = StIdle;
        else if (valid_q[idx] && dirty_q[idx]) state_d = StEvictReq;
        else                                   state_d = StFillReq;
      end
      StEvictReq:  if (mem_req_ready) state_d = StEvictData;
      StEvictData: if (wbeat && last_beat) state_d = StFillReq;
      StFillReq:   if (mem_req_ready) state_d = StFillData;
      StFillData:  if (rbeat && last_beat) state_d = StReplay;
      StReplay:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_req_ready  = (state_q == StIdle) && !rst;
    cpu_resp_valid = do_access;
    cpu_resp_rdata = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_wvalid     = 1'b0;
    mem_wdata      = '0;
    if (do_access && !req_we_q) cpu_resp_rdata = data_q[idx][word];
    unique case (state_q)
      StEvictReq: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {tag_q[idx], idx, {OFF_W{1'b0}}};
      end
      StFillReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, idx, {OFF_W{1'b0}}};
      end
      StEvictData: begin
        mem_wvalid = 1'b1;
        mem_wdata  = data_q[idx][beat_q];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: fills, hits, stores, write-back, stalls and mid-burst reset.
module tb_dcache_wb;

  logic        clk, rst;
  logic        cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_resp_valid;
  logic [31:0] cpu_req_addr, cpu_req_wdata, cpu_resp_rdata;
  logic [3:0]  cpu_req_wstrb;
  logic        mem_req_valid, mem_req_we, mem_req_ready;
  logic [31:0] mem_req_addr, mem_wdata, mem_rdata;
  logic        mem_wvalid, mem_wready, mem_rvalid;

  int checks = 0;
  int errors = 0;

  dcache_wb dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_wstrb(cpu_req_wstrb),
    .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb);
    int n = 0;
    while (!cpu_req_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!cpu_req_ready) begin
      errors++;
      $display("FAIL cpu_issue_timeout: ready=%0b required 1", cpu_req_ready);
    end
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    cpu_req_wstrb = strb;
    step();
    cpu_req_valid = 1'b0;
  endtask

  task automatic mem_handshake(output logic we, output logic [31:0] addr);
    int n = 0;
    while (!mem_req_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!mem_req_valid) begin
      errors++;
      $display("FAIL mem_req_timeout: valid=%0b required 1", mem_req_valid);
    end
    we            = mem_req_we;
    addr          = mem_req_addr;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
  endtask

  task automatic mem_fill(input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = w[i];
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] rd);
    int n = 0;
    while (!cpu_resp_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!cpu_resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1", cpu_resp_valid);
    end
    rd = cpu_resp_rdata;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0 || cpu_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_cpu_out: ready=%b resp=%b rdata=%h required 0 0 0",
               cpu_req_ready, cpu_resp_valid, cpu_resp_rdata);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h0 ||
        mem_wvalid !== 1'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem_out: v=%b we=%b a=%h wv=%b wd=%h required all 0",
               mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b required 1", cpu_req_ready);
    end
  endtask

  task automatic test_fill_miss();
    logic we;
    logic [31:0] a, rd;
    cpu_issue(1'b0, 32'h40, 32'h0, 4'h0);
    mem_handshake(we, a);
    checks++;
    if (we !== 1'b0 || a !== 32'h40) begin
      errors++;
      $display("FAIL fill_req: we=%b addr=%h required 0 00000040", we, a);
    end
    mem_fill(32'h11, 32'h22, 32'h33, 32'h44);
    wait_resp(rd);
    checks++;
    if (rd !== 32'h11) begin
      errors++;
      $display("FAIL fill_rdata: got %h required 00000011", rd);
    end
    step();
  endtask

  task automatic test_hit_latency();
    cpu_issue(1'b0, 32'h44, 32'h0, 4'h0);
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h22 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL hit_1cycle: resp=%b rdata=%h memreq=%b required 1 00000022 0",
               cpu_resp_valid, cpu_resp_rdata, mem_req_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic r [4];
    logic [31:0] d0, d2;
    cpu_req_valid = 1'b1;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h48;
    for (int i = 0; i < 4; i++) begin
      step();
      r[i] = cpu_resp_valid;
      if (i == 0) begin
        d0 = cpu_resp_rdata;
        cpu_req_addr = 32'h4C;
      end
      if (i == 2) begin
        d2 = cpu_resp_rdata;
        cpu_req_valid = 1'b0;
      end
    end
    checks++;
    if ({r[0], r[1], r[2], r[3]} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_pattern: got %b%b%b%b required 1010", r[0], r[1], r[2], r[3]);
    end
    checks++;
    if (d0 !== 32'h33 || d2 !== 32'h44) begin
      errors++;
      $display("FAIL b2b_rdata: got %h %h required 00000033 00000044", d0, d2);
    end
  endtask

  task automatic test_store_hit();
    cpu_issue(1'b1, 32'h44, 32'hAABBCCDD, 4'b0101);
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_resp: resp=%b rdata=%h required 1 00000000",
               cpu_resp_valid, cpu_resp_rdata);
    end
    step();
    cpu_issue(1'b0, 32'h44, 32'h0, 4'h0);
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h00BB00DD) begin
      errors++;
      $display("FAIL store_merge: resp=%b rdata=%h required 1 00bb00dd",
               cpu_resp_valid, cpu_resp_rdata);
    end
    step();
    cpu_issue(1'b1, 32'h48, 32'hFFFFFFFF, 4'b0000);
    step();
    cpu_issue(1'b0, 32'h48, 32'h0, 4'h0);
    checks++;
    if (cpu_resp_valid !== 1'b1 || cpu_resp_rdata !== 32'h33) begin
      errors++;
      $display("FAIL wstrb_zero: resp=%b rdata=%h required 1 00000033",
               cpu_resp_valid, cpu_resp_rdata);
    end
    step();
  endtask

  task automatic test_writeback();
    logic we;
    logic [31:0] a, rd, prev;
    logic [31:0] exp_wb [4];
    logic [31:0] got_wb [4];
    logic stalled = 1'b0;
    logic tgl = 1'b1;
    int n = 0;
    int cyc = 0;
    int unstable = 0;
    exp_wb = '{32'h11, 32'h00BB00DD, 32'h33, 32'h44};
    got_wb = '{32'h0, 32'h0, 32'h0, 32'h0};
    prev = 32'h0;
    cpu_issue(1'b0, 32'h440, 32'h0, 4'h0);
    mem_handshake(we, a);
    checks++;
    if (we !== 1'b1 || a !== 32'h40) begin
      errors++;
      $display("FAIL wb_req: we=%b addr=%h required 1 00000040", we, a);
    end
    while (n < 4 && cyc < 30) begin
      tgl = ~tgl;
      mem_wready = tgl;
      if (mem_wvalid) begin
        if (stalled && mem_wdata !== prev) unstable++;
        if (mem_wready) begin
          got_wb[n] = mem_wdata;
          n++;
          stalled = 1'b0;
        end else begin
          prev = mem_wdata;
          stalled = 1'b1;
        end
      end
      step();
      cyc++;
    end
    mem_wready = 1'b0;
    checks++;
    if (n != 4 || unstable != 0) begin
      errors++;
      $display("FAIL wb_beats: beats=%0d unstable=%0d required 4 0", n, unstable);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_wb[i] !== exp_wb[i]) begin
        errors++;
        $display("FAIL wb_data%0d: got %h required %h", i, got_wb[i], exp_wb[i]);
      end
    end
    mem_handshake(we, a);
    checks++;
    if (we !== 1'b0 || a !== 32'h440) begin
      errors++;
      $display("FAIL wb_fill_req: we=%b addr=%h required 0 00000440", we, a);
    end
    mem_fill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    wait_resp(rd);
    checks++;
    if (rd !== 32'hA0) begin
      errors++;
      $display("FAIL wb_fill_rdata: got %h required 000000a0", rd);
    end
    step();
  endtask

  task automatic test_clean_miss_stall();
    logic we;
    logic [31:0] a, rd;
    int bad = 0;
    cpu_issue(1'b0, 32'h848, 32'h0, 4'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h840 ||
          cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_stall: bad_cycles=%0d required 0", bad);
    end
    mem_handshake(we, a);
    checks++;
    if (we !== 1'b0 || a !== 32'h840) begin
      errors++;
      $display("FAIL clean_miss_req: we=%b addr=%h required 0 00000840", we, a);
    end
    mem_fill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    wait_resp(rd);
    checks++;
    if (rd !== 32'hB2) begin
      errors++;
      $display("FAIL clean_miss_rdata: got %h required 000000b2", rd);
    end
    step();
  endtask

  task automatic test_reset_mid_fill();
    logic we;
    logic [31:0] a, rd;
    cpu_issue(1'b0, 32'h80, 32'h0, 4'h0);
    mem_handshake(we, a);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hC0;
    step();
    mem_rdata  = 32'hC1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cpu_req_ready !== 1'b0 || cpu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
        mem_wvalid !== 1'b0 || mem_req_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL midfill_reset_out: rdy=%b resp=%b mv=%b wv=%b a=%h wd=%h required all 0",
               cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_wvalid, mem_req_addr, mem_wdata);
    end
    mem_rvalid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    cpu_issue(1'b0, 32'h80, 32'h0, 4'h0);
    mem_handshake(we, a);
    checks++;
    if (we !== 1'b0 || a !== 32'h80) begin
      errors++;
      $display("FAIL refill_req: we=%b addr=%h required 0 00000080", we, a);
    end
    mem_fill(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    wait_resp(rd);
    checks++;
    if (rd !== 32'hD0) begin
      errors++;
      $display("FAIL refill_rdata: got %h required 000000d0", rd);
    end
    step();
  endtask

  initial begin
    rst           = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_req_we    = 1'b0;
    cpu_req_addr  = 32'h0;
    cpu_req_wdata = 32'h0;
    cpu_req_wstrb = 4'h0;
    mem_req_ready = 1'b0;
    mem_wready    = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    test_reset();
    test_fill_miss();
    test_hit_latency();
    test_back_to_back();
    test_store_hit();
    test_writeback();
    test_clean_miss_stall();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
